alu_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters, e.g. the main core datapath (port 0) and a LUT/maintenance engine (port 1).
- Runs a request/acknowledge handshake and round-robin arbitration.
- Latches the winner's operands so the ALU inputs stay stable for a full cycle.
- Registers the ALU result and zero flag and returns them with a one-cycle Ack pulse.

---
 rtl/alu_arbiter_if.sv | 59 +++++
 rtl/alu_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side signal bundle for alu_arbiter.
// Lock0/Lock1 exist only when ALU_ARB_LOCK_EN is defined.
interface alu_arbiter_if #(
    parameter int DW   = 8,
    parameter int OPW  = 5,
    parameter int IMMW = 5
);
    logic            Req0;
    logic [OPW-1:0]  Op0;
    logic [DW-1:0]   A0;
    logic [DW-1:0]   B0;
    logic [IMMW-1:0] Imm0;
    logic            Req1;
    logic [OPW-1:0]  Op1;
    logic [DW-1:0]   A1;
    logic [DW-1:0]   B1;
    logic [IMMW-1:0] Imm1;
`ifdef ALU_ARB_LOCK_EN
    logic            Lock0;
    logic            Lock1;
`endif
    logic            Ack0;
    logic            Ack1;
    logic [DW-1:0]   RdData;
    logic            RdZero;
    logic            Busy;
    logic [OPW-1:0]  AluOp;
    logic [DW-1:0]   AluA;
    logic [DW-1:0]   AluB;
    logic [IMMW-1:0] AluImm;
    logic [DW-1:0]   AluOut;
    logic            AluZero;

    // Handshake: ReqN is held high until AckN; AckN is a one-cycle pulse
    // and ReqN must be low at the edge ending that pulse unless a new op is wanted.
`ifdef ALU_ARB_LOCK_EN
    modport slave (
        input  Req0, Op0, A0, B0, Imm0, Req1, Op1, A1, B1, Imm1, Lock0, Lock1,
        input  AluOut, AluZero,
        output Ack0, Ack1, RdData, RdZero, Busy, AluOp, AluA, AluB, AluImm
    );
    modport master (
        output Req0, Op0, A0, B0, Imm0, Req1, Op1, A1, B1, Imm1, Lock0, Lock1,
        output AluOut, AluZero,
        input  Ack0, Ack1, RdData, RdZero, Busy, AluOp, AluA, AluB, AluImm
    );
`else
    modport slave (
        input  Req0, Op0, A0, B0, Imm0, Req1, Op1, A1, B1, Imm1,
        input  AluOut, AluZero,
        output Ack0, Ack1, RdData, RdZero, Busy, AluOp, AluA, AluB, AluImm
    );
    modport master (
        output Req0, Op0, A0, B0, Imm0, Req1, Op1, A1, B1, Imm1,
        output AluOut, AluZero,
        input  Ack0, Ack1, RdData, RdZero, Busy, AluOp, AluA, AluB, AluImm
    );
`endif
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional ALU_ARB_LOCK_EN: a granted requester with Lock=1 keeps priority.
module alu_arbiter #(
    parameter int DW   = 8,
    parameter int OPW  = 5,
    parameter int IMMW = 5
) (
    input  logic         CLK,
    input  logic         Reset,
    alu_arbiter_if.slave bus,
    output logic [1:0]   dbg_state,
    output logic         dbg_ptr
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            gnt_q, gnt_d;
    logic            ptr_q, ptr_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [IMMW-1:0] imm_q, imm_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic            rd_zero_q, rd_zero_d;
    logic            any_req;
    logic            win_id;
`ifdef ALU_ARB_LOCK_EN
    logic            lock_q, lock_d;
`endif

    assign any_req = bus.Req0 | bus.Req1;
    // Pointer only breaks ties; a lone requester always wins.
    assign win_id  = (bus.Req0 & bus.Req1) ? ptr_q : bus.Req1;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        rd_data_d = rd_data_q;
        rd_zero_d = rd_zero_q;
`ifdef ALU_ARB_LOCK_EN
        lock_d    = lock_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = EXEC;
                    gnt_d   = win_id;
                    if (win_id) begin
                        op_d  = bus.Op1;
                        a_d   = bus.A1;
                        b_d   = bus.B1;
                        imm_d = bus.Imm1;
`ifdef ALU_ARB_LOCK_EN
                        lock_d = bus.Lock1;
`endif
                    end else begin
                        op_d  = bus.Op0;
                        a_d   = bus.A0;
                        b_d   = bus.B0;
                        imm_d = bus.Imm0;
`ifdef ALU_ARB_LOCK_EN
                        lock_d = bus.Lock0;
`endif
                    end
                end
            end
            EXEC: begin
                rd_data_d = bus.AluOut;
                rd_zero_d = bus.AluZero;
                state_d   = RESP;
            end
            RESP: begin
                state_d = IDLE;
`ifdef ALU_ARB_LOCK_EN
                ptr_d = lock_q ? gnt_q : ~gnt_q;
`else
                ptr_d = ~gnt_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            ptr_q     <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            rd_data_q <= '0;
            rd_zero_q <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
            lock_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            rd_data_q <= rd_data_d;
            rd_zero_q <= rd_zero_d;
`ifdef ALU_ARB_LOCK_EN
            lock_q    <= lock_d;
`endif
        end
    end

    assign bus.Ack0   = (state_q == RESP) && !gnt_q;
    assign bus.Ack1   = (state_q == RESP) && gnt_q;
    assign bus.Busy   = (state_q == EXEC) || (state_q == RESP);
    assign bus.RdData = rd_data_q;
    assign bus.RdZero = rd_zero_q;
    assign bus.AluOp  = op_q;
    assign bus.AluA   = a_q;
    assign bus.AluB   = b_q;
    assign bus.AluImm = imm_q;
    assign dbg_state  = state_q;
    assign dbg_ptr    = ptr_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed timing/arbitration cases plus random traffic,
// with per-requester expected queues popped by an Ack monitor.
module tb_alu_arbiter;
    localparam int DW = 8, OPW = 5, IMMW = 5;
    localparam logic [4:0] O_ADD = 5'd0, O_ADDI = 5'd1, O_SUB = 5'd2,
                           O_SUBI = 5'd3, O_XOR = 5'd4, O_AND = 5'd5, O_BAD = 5'd31;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.DW(DW), .OPW(OPW), .IMMW(IMMW)) bus ();
    logic [1:0] dbg_state;
    logic       dbg_ptr;

    alu_arbiter #(.DW(DW), .OPW(OPW), .IMMW(IMMW)) dut (
        .CLK(clk), .Reset(rst), .bus(bus), .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [DW:0] exp_q0[$];
    logic [DW:0] exp_q1[$];
    int ack_id_q[$];
    int ack_cyc_q[$];

    // Reference ALU: {zero, result}; unknown opcodes give 0 with zero set.
    function automatic logic [DW:0] ref_alu(input logic [4:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [4:0] imm);
        logic [7:0] r;
        case (op)
            O_ADD:   r = a + b;
            O_ADDI:  r = a + {3'b000, imm};
            O_SUB:   r = a - b;
            O_SUBI:  r = a - {3'b000, imm};
            O_XOR:   r = a ^ b;
            O_AND:   r = a & b;
            default: r = 8'h00;
        endcase
        return {(r == 8'h00), r};
    endfunction

    logic [DW:0] alu_w;
    assign alu_w       = ref_alu(bus.AluOp, bus.AluA, bus.AluB, bus.AluImm);
    assign bus.AluOut  = alu_w[DW-1:0];
    assign bus.AluZero = alu_w[DW];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_ack(input int port);
        logic [DW:0] e;
        ack_id_q.push_back(port);
        ack_cyc_q.push_back(cyc);
        if ((port == 0 && exp_q0.size() == 0) || (port == 1 && exp_q1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL ack_unexpected port=%0d act=1 exp=0 t=%0t", port, $time);
        end else begin
            e = (port == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk("rd_data", {24'h0, bus.RdData}, {24'h0, e[DW-1:0]});
            chk("rd_zero", {31'h0, bus.RdZero}, {31'h0, e[DW]});
        end
    endtask

    // Monitor: every Ack must match the oldest outstanding op of that requester.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.Ack0 && bus.Ack1) begin
                total++;
                bad++;
                $display("FAIL ack_both act=11 exp=one_hot t=%0t", $time);
            end
            if (bus.Ack0) check_ack(0);
            if (bus.Ack1) check_ack(1);
        end
    end

    task automatic drive_req(input int port, input logic [4:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic [4:0] imm);
        if (port == 0) begin
            bus.Op0 = op; bus.A0 = a; bus.B0 = b; bus.Imm0 = imm; bus.Req0 = 1'b1;
        end else begin
            bus.Op1 = op; bus.A1 = a; bus.B1 = b; bus.Imm1 = imm; bus.Req1 = 1'b1;
        end
    endtask

    task automatic push_exp(input int port, input logic [4:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [4:0] imm);
        if (port == 0) exp_q0.push_back(ref_alu(op, a, b, imm));
        else           exp_q1.push_back(ref_alu(op, a, b, imm));
    endtask

    // One full transaction; n = negedges seen before the Ack (2 when uncontended).
    task automatic do_txn(input int port, input logic [4:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [4:0] imm, output int n);
        bit got;
        got = 0;
        n = 0;
        @(posedge clk);
        #1;
        push_exp(port, op, a, b, imm);
        drive_req(port, op, a, b, imm);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (port == 0 ? bus.Ack0 : bus.Ack1) got = 1;
            else n++;
        end
        if (port == 0) bus.Req0 = 1'b0;
        else           bus.Req1 = 1'b0;
        chk($sformatf("txn_ack_port%0d", port), {31'h0, got}, 32'd1);
    endtask

    task automatic rand_port(input int port);
        logic [4:0] op;
        int n;
        repeat (15) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            case ($urandom_range(0, 6))
                0: op = O_ADD;
                1: op = O_ADDI;
                2: op = O_SUB;
                3: op = O_SUBI;
                4: op = O_XOR;
                5: op = O_AND;
                default: op = O_BAD;
            endcase
            do_txn(port, op, 8'($urandom), 8'($urandom), 5'($urandom), n);
        end
    endtask

    task automatic check_order(input string name, input int e0, input int e1,
                               input int e2, input int e3);
        int exp_ids[4];
        exp_ids = '{e0, e1, e2, e3};
        chk({name, "_ack_count"}, ack_id_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < ack_id_q.size(); i++) begin
            chk($sformatf("%s_ack%0d_id", name, i), ack_id_q[i], exp_ids[i]);
            if (i > 0) chk($sformatf("%s_ack%0d_gap", name, i), ack_cyc_q[i] - ack_cyc_q[i-1], 32'd3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.Req0 = 0; bus.Op0 = '0; bus.A0 = '0; bus.B0 = '0; bus.Imm0 = '0;
        bus.Req1 = 0; bus.Op1 = '0; bus.A1 = '0; bus.B1 = '0; bus.Imm1 = '0;
`ifdef ALU_ARB_LOCK_EN
        bus.Lock0 = 1'b0; bus.Lock1 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", {30'h0, dbg_state}, 32'd0);
        chk("rst_busy", {31'h0, bus.Busy}, 32'd0);
        chk("rst_ack", {30'h0, bus.Ack1, bus.Ack0}, 32'd0);
        chk("rst_rd_data", {24'h0, bus.RdData}, 32'd0);
        chk("rst_ptr", {31'h0, dbg_ptr}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single request: exact Ack timing, operand changes after grant ignored.
        @(posedge clk); #1;
        push_exp(0, O_ADD, 8'h05, 8'h0A, 5'd0);
        drive_req(0, O_ADD, 8'h05, 8'h0A, 5'd0);
        @(posedge clk); #1;
        chk("t_single_exec", {30'h0, dbg_state}, 32'd1);
        chk("t_single_busy", {31'h0, bus.Busy}, 32'd1);
        chk("t_single_alu_a", {24'h0, bus.AluA}, 32'h05);
        chk("t_single_alu_b", {24'h0, bus.AluB}, 32'h0A);
        bus.A0 = 8'hFF;
        bus.Req0 = 1'b0;
        @(posedge clk); #1;
        chk("t_single_ack0", {31'h0, bus.Ack0}, 32'd1);
        chk("t_single_ack1", {31'h0, bus.Ack1}, 32'd0);
        @(posedge clk); #1;
        chk("t_single_ack0_end", {31'h0, bus.Ack0}, 32'd0);
        chk("t_single_busy_end", {31'h0, bus.Busy}, 32'd0);
        chk("t_single_hold", {24'h0, bus.RdData}, 32'h0F);
        chk("t_single_ptr", {31'h0, dbg_ptr}, 32'd1);

        // Reset in EXEC discards the op.
        @(posedge clk); #1;
        drive_req(0, O_ADD, 8'd3, 8'd4, 5'd0);
        @(posedge clk); #1;
        bus.Req0 = 1'b0;
        chk("t_rst_exec", {30'h0, dbg_state}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t_rst_state", {30'h0, dbg_state}, 32'd0);
        chk("t_rst_ack0", {31'h0, bus.Ack0}, 32'd0);
        chk("t_rst_rd_data", {24'h0, bus.RdData}, 32'd0);
        chk("t_rst_ptr", {31'h0, dbg_ptr}, 32'd0);
        chk("t_rst_alu_a", {24'h0, bus.AluA}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        // Zero result on requester 1, two cycles of latency.
        do_txn(1, O_XOR, 8'h5A, 8'h5A, 5'd0, n);
        chk("t_zero_latency", n, 32'd2);

        // Contention: alternating grants, one Ack per 3 cycles.
        @(posedge clk); #1;
        ack_id_q.delete(); ack_cyc_q.delete();
        repeat (2) begin
            push_exp(0, O_ADDI, 8'd1, 8'd0, 5'd2);
            push_exp(1, O_SUB, 8'd9, 8'd4, 5'd4);
        end
        drive_req(0, O_ADDI, 8'd1, 8'd0, 5'd2);
        drive_req(1, O_SUB, 8'd9, 8'd4, 5'd4);
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (i == 12) begin bus.Req0 = 1'b0; bus.Req1 = 1'b0; end
        end
        check_order("t_cont", 0, 1, 0, 1);

        // Withdraw: Req1 raised during EXEC of a port-0 op, dropped before IDLE.
        @(posedge clk); #1;
        push_exp(0, O_ADD, 8'd1, 8'd1, 5'd0);
        drive_req(0, O_ADD, 8'd1, 8'd1, 5'd0);
        @(posedge clk); #1;
        drive_req(1, O_ADD, 8'd7, 8'd7, 5'd0);
        @(posedge clk); #1;
        chk("t_wd_ack0", {31'h0, bus.Ack0}, 32'd1);
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        @(posedge clk); #1;
        chk("t_wd_busy", {31'h0, bus.Busy}, 32'd0);
        @(posedge clk); #1;
        chk("t_wd_idle", {30'h0, dbg_state}, 32'd0);

`ifdef ALU_ARB_LOCK_EN
        do_txn(1, O_AND, 8'hF0, 8'h3C, 5'd0, n);
        @(posedge clk); #1;
        ack_id_q.delete(); ack_cyc_q.delete();
        repeat (3) push_exp(0, O_ADD, 8'd2, 8'd2, 5'd0);
        push_exp(1, O_SUBI, 8'd9, 8'd0, 5'd1);
        drive_req(0, O_ADD, 8'd2, 8'd2, 5'd0);
        drive_req(1, O_SUBI, 8'd9, 8'd0, 5'd1);
        bus.Lock0 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (i == 5) bus.Lock0 = 1'b0;
            if (i == 12) begin bus.Req0 = 1'b0; bus.Req1 = 1'b0; end
        end
        check_order("t_lock", 0, 0, 0, 1);
`endif

        // Random concurrent traffic from both requesters.
        fork
            rand_port(0);
            rand_port(1);
        join
        repeat (5) @(posedge clk);
        chk("q0_empty", exp_q0.size(), 32'd0);
        chk("q1_empty", exp_q1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
